// File: rtl/branch_resolver.sv
// Branch resolver: in-order prediction FIFO checked against backend outcomes; emits mispredict/redirect pulses and fetch stall.
// Optional BRANCH_RESOLVE_STAT_EN adds saturating resolve/mispredict counters.
module branch_resolver #(
    parameter int BHT_DP = 4
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        bht_push,
    input  logic        bht_predict,
    input  logic [63:0] bht_altpc,
    input  logic        jalr_issue,
    output logic        bht_full,
    output logic        bht_empty,
    output logic        fetch_stall,
    input  logic        takenBranch_vaild_qout,
    input  logic        takenBranch_qout,
    input  logic        jalr_vaild_qout,
    input  logic [63:0] jalr_pc_qout,
    input  logic        isFlush,
    input  logic        privileged_vaild,
    input  logic [63:0] privileged_pc,
    output logic        isMisPredict,
    output logic        redirect_vaild,
    output logic [63:0] redirect_pc
`ifdef BRANCH_RESOLVE_STAT_EN
    ,
    output logic [31:0] stat_resolved,
    output logic [31:0] stat_mispredict
`endif
);
    localparam int AW = $clog2(BHT_DP);

    typedef enum logic [1:0] {RUN, JALR_WAIT, MISP_WAIT} state_t;

    state_t            state_q, state_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [BHT_DP-1:0] pred_q;
    logic [63:0]       altpc_q [BHT_DP];
    logic              misp_q, misp_d, rv_q, rv_d;
    logic [63:0]       rpc_q, rpc_d;
    logic              flush, pop_en, push_en, mispredict;
    logic              head_pred;
    logic [63:0]       head_alt;

    assign head_pred = pred_q[rd_ptr_q[AW-1:0]];
    assign head_alt  = altpc_q[rd_ptr_q[AW-1:0]];

    assign bht_empty   = (rd_ptr_q == wr_ptr_q);
    assign bht_full    = (rd_ptr_q[AW] != wr_ptr_q[AW]) && (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]);
    assign fetch_stall = (state_q != RUN) | bht_full;

    assign isMisPredict   = misp_q;
    assign redirect_vaild = rv_q;
    assign redirect_pc    = rpc_q;

    // Flush outranks everything; a mispredict squashes any same-cycle push (it is wrong-path too).
    assign flush      = isFlush | privileged_vaild;
    assign pop_en     = !flush && takenBranch_vaild_qout && (state_q != MISP_WAIT) && !bht_empty;
    assign mispredict = pop_en && (takenBranch_qout != head_pred);
    assign push_en    = !flush && !mispredict && bht_push && (state_q == RUN) && !bht_full;

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        misp_d   = 1'b0;
        rv_d     = 1'b0;
        rpc_d    = rpc_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            state_d  = RUN;
            if (privileged_vaild) begin
                rv_d  = 1'b1;
                rpc_d = privileged_pc;
            end
        end else if (mispredict) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            state_d  = MISP_WAIT;
            misp_d   = 1'b1;
            rv_d     = 1'b1;
            rpc_d    = head_alt;
        end else begin
            if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
            case (state_q)
                RUN: if (jalr_issue) state_d = JALR_WAIT;
                JALR_WAIT: if (jalr_vaild_qout) begin
                    state_d = RUN;
                    rv_d    = 1'b1;
                    rpc_d   = jalr_pc_qout;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q  <= RUN;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            misp_q   <= 1'b0;
            rv_q     <= 1'b0;
            rpc_q    <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            misp_q   <= misp_d;
            rv_q     <= rv_d;
            rpc_q    <= rpc_d;
        end
    end

    // Entry storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge CLK) begin
        if (push_en) begin
            pred_q[wr_ptr_q[AW-1:0]]  <= bht_predict;
            altpc_q[wr_ptr_q[AW-1:0]] <= bht_altpc;
        end
    end

`ifdef BRANCH_RESOLVE_STAT_EN
    logic [31:0] res_cnt_q, mis_cnt_q;

    assign stat_resolved   = res_cnt_q;
    assign stat_mispredict = mis_cnt_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            res_cnt_q <= '0;
            mis_cnt_q <= '0;
        end else begin
            if (pop_en && (res_cnt_q != 32'hFFFF_FFFF))     res_cnt_q <= res_cnt_q + 32'd1;
            if (mispredict && (mis_cnt_q != 32'hFFFF_FFFF)) mis_cnt_q <= mis_cnt_q + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: queue-based reference model, directed scenarios, then random traffic.
module tb_branch_resolver;
    localparam int DP = 4;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        bht_push = 1'b0, bht_predict = 1'b0, jalr_issue = 1'b0;
    logic [63:0] bht_altpc = '0, jalr_pc_qout = '0, privileged_pc = '0;
    logic        takenBranch_vaild_qout = 1'b0, takenBranch_qout = 1'b0, jalr_vaild_qout = 1'b0;
    logic        isFlush = 1'b0, privileged_vaild = 1'b0;
    logic        bht_full, bht_empty, fetch_stall, isMisPredict, redirect_vaild;
    logic [63:0] redirect_pc;
`ifdef BRANCH_RESOLVE_STAT_EN
    logic [31:0] stat_resolved, stat_mispredict;
`endif

    branch_resolver #(.BHT_DP(DP)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .bht_push(bht_push), .bht_predict(bht_predict), .bht_altpc(bht_altpc),
        .jalr_issue(jalr_issue), .bht_full(bht_full), .bht_empty(bht_empty),
        .fetch_stall(fetch_stall),
        .takenBranch_vaild_qout(takenBranch_vaild_qout), .takenBranch_qout(takenBranch_qout),
        .jalr_vaild_qout(jalr_vaild_qout), .jalr_pc_qout(jalr_pc_qout),
        .isFlush(isFlush), .privileged_vaild(privileged_vaild), .privileged_pc(privileged_pc),
        .isMisPredict(isMisPredict), .redirect_vaild(redirect_vaild), .redirect_pc(redirect_pc)
`ifdef BRANCH_RESOLVE_STAT_EN
        , .stat_resolved(stat_resolved), .stat_mispredict(stat_mispredict)
`endif
    );

    always #5 CLK = ~CLK;

    int n_vec = 0, n_cmp = 0, n_err = 0;
    bit chk_en = 1'b1;

    // Reference model: outstanding predictions as a queue of {predict, altpc}.
    logic [64:0] mq[$];
    bit          m_jalr_pending, m_misp_pending;
    bit          e_misp, e_rv;
    logic [63:0] e_rpc;
    longint      m_res, m_mis;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_jalr_pending = 0; m_misp_pending = 0;
        e_misp = 0; e_rv = 0; e_rpc = '0;
        m_res = 0; m_mis = 0;
    endtask

    task automatic model_step();
        bit running, was_full, resolving, pushing;
        running = !m_jalr_pending && !m_misp_pending;
        e_misp = 0;
        e_rv   = 0;
        if (isFlush || privileged_vaild) begin
            mq.delete();
            m_jalr_pending = 0; m_misp_pending = 0;
            if (privileged_vaild) begin e_rv = 1; e_rpc = privileged_pc; end
        end else begin
            was_full  = (mq.size() == DP);
            resolving = takenBranch_vaild_qout && !m_misp_pending && (mq.size() > 0);
            if (resolving && (takenBranch_qout != mq[0][64])) begin
                e_rv = 1; e_misp = 1; e_rpc = mq[0][63:0];
                mq.delete();
                m_misp_pending = 1; m_jalr_pending = 0;
                m_res++; m_mis++;
            end else begin
                pushing = bht_push && running && !was_full;
                if (resolving) begin void'(mq.pop_front()); m_res++; end
                if (pushing) mq.push_back({bht_predict, bht_altpc});
                if (running && jalr_issue) m_jalr_pending = 1;
                else if (m_jalr_pending && jalr_vaild_qout) begin
                    m_jalr_pending = 0; e_rv = 1; e_rpc = jalr_pc_qout;
                end
            end
        end
    endtask

    task automatic compare_all();
        n_vec++;
        check("isMisPredict", {63'd0, isMisPredict}, {63'd0, e_misp});
        check("redirect_vaild", {63'd0, redirect_vaild}, {63'd0, e_rv});
        check("redirect_pc", redirect_pc, e_rpc);
        check("bht_empty", {63'd0, bht_empty}, {63'd0, mq.size() == 0});
        check("bht_full", {63'd0, bht_full}, {63'd0, mq.size() == DP});
        check("fetch_stall", {63'd0, fetch_stall},
              {63'd0, m_jalr_pending || m_misp_pending || (mq.size() == DP)});
`ifdef BRANCH_RESOLVE_STAT_EN
        check("stat_resolved", {32'd0, stat_resolved}, (m_res > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_res);
        check("stat_mispredict", {32'd0, stat_mispredict}, (m_mis > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_mis);
`endif
    endtask

    always @(posedge CLK) begin
        if (!RSTn) model_reset();
        else       model_step();
        #1;
        if (chk_en) compare_all();
    end

    task automatic idle();
        bht_push = 0; bht_predict = 0; bht_altpc = '0; jalr_issue = 0;
        takenBranch_vaild_qout = 0; takenBranch_qout = 0;
        jalr_vaild_qout = 0; jalr_pc_qout = '0;
        isFlush = 0; privileged_vaild = 0; privileged_pc = '0;
    endtask

    task automatic go();
        @(posedge CLK);
        #2;
        idle();
    endtask

    task automatic push(input logic p, input logic [63:0] a);
        bht_push = 1; bht_predict = p; bht_altpc = a;
        go();
    endtask

    task automatic resolve(input logic t);
        takenBranch_vaild_qout = 1; takenBranch_qout = t;
        go();
    endtask

    initial begin
        idle();
        go(); go();
        check("rst_redirect_pc", redirect_pc, 64'd0);
        check("rst_empty", {63'd0, bht_empty}, 64'd1);
        RSTn = 1;
        go();

        // Correct predictions drain without pulses.
        push(1, 64'h100); push(0, 64'h200); push(1, 64'h300);
        resolve(1); resolve(0);
        check("t1_no_misp", {63'd0, isMisPredict}, 64'd0);
        resolve(1);
        check("t1_empty", {63'd0, bht_empty}, 64'd1);

        // Mispredict redirects to the alternate PC and stalls until flush.
        push(1, 64'h8000_0040);
        resolve(0);
        check("t2_misp", {63'd0, isMisPredict}, 64'd1);
        check("t2_redirect_pc", redirect_pc, 64'h8000_0040);
        check("t2_empty", {63'd0, bht_empty}, 64'd1);
        go();
        check("t2_pulse_end", {63'd0, isMisPredict}, 64'd0);
        check("t2_stall", {63'd0, fetch_stall}, 64'd1);
`ifdef BRANCH_RESOLVE_STAT_EN
        check("t2_stat_res", {32'd0, stat_resolved}, 64'd4);
        check("t2_stat_mis", {32'd0, stat_mispredict}, 64'd1);
`endif
        isFlush = 1;
        go();
        check("t2_released", {63'd0, fetch_stall}, 64'd0);
        check("t2_no_redirect", {63'd0, redirect_vaild}, 64'd0);

        // Full FIFO drops pushes; push+pop while full leaves three entries.
        for (int i = 0; i < DP; i++) push(1, 64'h1000 + 64'(i));
        check("t3_full", {63'd0, bht_full}, 64'd1);
        push(1, 64'hDEAD);
        check("t3_still_full", {63'd0, bht_full}, 64'd1);
        bht_push = 1; bht_predict = 1; bht_altpc = 64'hBEEF;
        resolve(1);
        check("t3_not_full", {63'd0, bht_full}, 64'd0);
        resolve(1); resolve(1);
        check("t3_one_left", {63'd0, bht_empty}, 64'd0);
        resolve(1);
        check("t3_drained", {63'd0, bht_empty}, 64'd1);

        // Jalr stall released by the resolved target.
        jalr_issue = 1;
        go();
        check("t4_stall", {63'd0, fetch_stall}, 64'd1);
        go(); go();
        jalr_vaild_qout = 1; jalr_pc_qout = 64'h8000_1000;
        go();
        check("t4_redirect_vld", {63'd0, redirect_vaild}, 64'd1);
        check("t4_redirect_pc", redirect_pc, 64'h8000_1000);
        check("t4_unstall", {63'd0, fetch_stall}, 64'd0);

        // Privileged redirect beats a same-cycle mispredict.
        push(1, 64'h999);
        privileged_vaild = 1; privileged_pc = 64'h8000_0000;
        resolve(0);
        check("t5_redirect_pc", redirect_pc, 64'h8000_0000);
        check("t5_no_misp", {63'd0, isMisPredict}, 64'd0);
        check("t5_empty", {63'd0, bht_empty}, 64'd1);
        check("t5_run", {63'd0, fetch_stall}, 64'd0);

        // Resolve on empty FIFO, then asynchronous reset mid jalr wait.
        resolve(0);
        check("t6_no_pulse", {63'd0, redirect_vaild | isMisPredict}, 64'd0);
        jalr_issue = 1;
        go();
        push(0, 64'h55);
        RSTn = 0;
        #1;
        check("t6_rst_pc", redirect_pc, 64'd0);
        check("t6_rst_stall", {63'd0, fetch_stall}, 64'd0);
        check("t6_rst_empty", {63'd0, bht_empty}, 64'd1);
        check("t6_rst_full", {63'd0, bht_full}, 64'd0);
        check("t6_rst_rv", {63'd0, redirect_vaild | isMisPredict}, 64'd0);
        go();
        RSTn = 1;
        go();

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            bht_push               = ($urandom_range(0, 1) == 1);
            bht_predict            = $urandom_range(0, 1);
            bht_altpc              = {$urandom, $urandom};
            jalr_issue             = ($urandom_range(0, 15) == 0);
            takenBranch_vaild_qout = ($urandom_range(0, 2) == 0);
            takenBranch_qout       = ($urandom_range(0, 3) != 0);
            jalr_vaild_qout        = ($urandom_range(0, 4) == 0);
            jalr_pc_qout           = {$urandom, $urandom};
            isFlush                = ($urandom_range(0, 19) == 0);
            privileged_vaild       = ($urandom_range(0, 39) == 0);
            privileged_pc          = {$urandom, $urandom};
            @(posedge CLK);
            #2;
        end
        idle();
        go();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
